mem_burst_adapter: RTL and testbench
====================================

MEM_BURST_ADAPTER -- requirements
Module: mem_burst_adapter

Interface
REQ-001 SHALL have parameter CACHELINE_BIT_WIDTH, default 256: cache line width in bits.
REQ-002 SHALL have parameter BURST_WIDTH, default 64: memory beat width in bits. CACHELINE_BIT_WIDTH/BURST_WIDTH = BEATS (default 4), a power of two, at least 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-004 SHALL have parameter OFFSET_BITS, default 5: line-offset bits in the address.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 SHALL have ports, in this order:
- clk: input, 1 bit. Sole clock; rising edge.
- rst_n: input, 1 bit. Asynchronous reset, active low.
- line_i: input, CACHELINE_BIT_WIDTH bits. Line to write, from the cache.
- line_o: output, CACHELINE_BIT_WIDTH bits. Assembled read line, to the cache.
- address_i: input, ADDR_WIDTH bits. Line address, from the cache.
- read_i: input, 1 bit. Cache line-read request; level, held until resp_o.
- write_i: input, 1 bit. Cache line-write request; level, held until resp_o.
- resp_o: output, 1 bit. One-cycle completion pulse, to the cache.
- burst_i: input, BURST_WIDTH bits. Read beat data, from memory.
- burst_o: output, BURST_WIDTH bits. Write beat data, to memory.
- address_o: output, ADDR_WIDTH bits. Line-aligned burst address.
- read_o: output, 1 bit. Memory burst-read request.
- write_o: output, 1 bit. Memory burst-write request.
- resp_i: input, 1 bit. Memory beat acknowledge; one per beat.

Function
REQ-007 SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-008 In IDLE, when read_i=1 at a rising edge, the FSM SHALL go to READ. When write_i=1 and read_i=0, it SHALL go to WRITE. When both are 1, read SHALL take priority.
REQ-009 On leaving IDLE, the block SHALL latch address_o = address_i with bits [OFFSET_BITS-1:0] forced to 0.
REQ-010 On leaving IDLE for WRITE, the block SHALL latch line_i into an internal buffer. Later changes on line_i and address_i SHALL be ignored until IDLE.
REQ-011 The block SHALL clear the beat counter (log2(BEATS) bits) to 0 on leaving IDLE.
REQ-012 read_o SHALL be 1 exactly while the state is READ; write_o SHALL be 1 exactly while the state is WRITE.
REQ-013 In READ, each cycle with resp_i=1 SHALL capture burst_i into line_o[count*BURST_WIDTH +: BURST_WIDTH] and increment the counter.
REQ-014 In WRITE, burst_o SHALL equal buffer[count*BURST_WIDTH +: BURST_WIDTH]. Each cycle with resp_i=1 SHALL increment the counter.
REQ-015 When resp_i=1 while count = BEATS-1, the FSM SHALL go to DONE and the counter SHALL wrap to 0.
REQ-016 resp_i with no beat in progress (IDLE or DONE) SHALL be ignored.
REQ-017 resp_o SHALL be 1 for exactly the one DONE cycle; DONE SHALL always go to IDLE.
REQ-018 The cache SHALL drop read_i/write_i in the cycle after resp_o. Any request still high in IDLE SHALL start a new transaction.
REQ-019 line_o SHALL hold its value from the last completed read until the next read beat 0 is captured. Write transactions SHALL NOT modify line_o.
REQ-020 Minimum latency, with resp_i=1 on every cycle of the burst: request sampled at edge N, read_o/write_o high in cycles N+1 through N+BEATS, resp_o high in cycle N+BEATS+1.
REQ-021 Stall cycles (resp_i=0) SHALL hold the state, counter, burst_o and address_o unchanged.
REQ-022 burst_o SHALL be 0 outside WRITE.

Reset
REQ-023 On rst_n=0, the block SHALL asynchronously force: state IDLE, counter 0, line_o 0, internal buffer 0, burst_o 0, address_o 0, read_o 0, write_o 0, resp_o 0.
REQ-024 Reset asserted mid-burst SHALL abort the transaction with no resp_o; the memory side sees read_o/write_o drop immediately.
REQ-025 After rst_n rises, the first request SHALL be sampled on the first rising edge at which rst_n=1.

Verification
REQ-026 Read, no stalls: address_i=0x0000_1234, read_i=1, burst_i = 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> address_o=0x0000_1220, read_o high 4 cycles, resp_o in cycle 5, line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
REQ-027 Write with stalls: line_i = {D3, D2, D1, D0}, write_i=1, resp_i pattern 1,0,0,1,1,0,1 -> burst_o shows D0, D1, D1, D1, D2, D3, D3, write_o high 7 cycles, resp_o one cycle after the last beat, line_o unchanged.
REQ-028 read_i=write_i=1 together in IDLE -> read burst performed; write_o never asserted.
REQ-029 rst_n=0 after 2 read beats -> all outputs 0 at once, no resp_o; a following full read completes with the correct line.
REQ-030 resp_i pulsed in IDLE, then a read performed -> counter unaffected; beat 0 lands in line_o[63:0].
REQ-031 Back-to-back: read_i still high in the cycle after resp_o -> a second read starts; read_o reasserts one cycle after DONE.

Source files
------------

// File: rtl/mem_burst_adapter.sv
// Cache-line to memory-burst adapter: splits a line write into BEATS beats and
// assembles BEATS read beats into a line, one beat per memory acknowledge.
module mem_burst_adapter #(
   parameter int CACHELINE_BIT_WIDTH = 256,
   parameter int BURST_WIDTH         = 64,
   parameter int ADDR_WIDTH          = 32,
   parameter int OFFSET_BITS         = 5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CACHELINE_BIT_WIDTH-1:0] line_i,
   output logic [CACHELINE_BIT_WIDTH-1:0] line_o,
   input  logic [ADDR_WIDTH-1:0]          address_i,
   input  logic                           read_i,
   input  logic                           write_i,
   output logic                           resp_o,
   input  logic [BURST_WIDTH-1:0]         burst_i,
   output logic [BURST_WIDTH-1:0]         burst_o,
   output logic [ADDR_WIDTH-1:0]          address_o,
   output logic                           read_o,
   output logic                           write_o,
   input  logic                           resp_i
);

   localparam int BEATS = CACHELINE_BIT_WIDTH / BURST_WIDTH;
   localparam int CW    = $clog2(BEATS);
   localparam logic [CW-1:0]         LAST_BEAT  = CW'(BEATS - 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

   state_e                         state_q, state_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [CACHELINE_BIT_WIDTH-1:0] buf_q;
   logic [CACHELINE_BIT_WIDTH-1:0] line_q;
   logic [BURST_WIDTH-1:0]         burst_q;
   logic [ADDR_WIDTH-1:0]          addr_q;
   logic                           rd_q, wr_q, resp_q;
   logic                           beat;

   // An acknowledge only counts while a burst is actually in flight.
   assign beat = resp_i && (state_q == READ || state_q == WRITE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (read_i)       state_d = READ;
            else if (write_i) state_d = WRITE;
         end
         READ, WRITE: begin
            if (beat) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_BEAT) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         line_q  <= '0;
         burst_q <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= (state_d == READ);
         wr_q    <= (state_d == WRITE);
         resp_q  <= (state_d == DONE);

         if (state_q == IDLE && state_d != IDLE) begin
            addr_q <= address_i & ALIGN_MASK;
            if (state_d == WRITE) buf_q <= line_i;
         end

         if (state_q == READ && resp_i)
            line_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] <= burst_i;

         // Beat 0 comes straight from line_i since the buffer loads on the same edge.
         if (state_d == WRITE) begin
            if (state_q == IDLE) burst_q <= line_i[BURST_WIDTH-1:0];
            else                 burst_q <= buf_q[int'(cnt_d)*BURST_WIDTH +: BURST_WIDTH];
         end else begin
            burst_q <= '0;
         end
      end
   end

   assign line_o    = line_q;
   assign burst_o   = burst_q;
   assign address_o = addr_q;
   assign read_o    = rd_q;
   assign write_o   = wr_q;
   assign resp_o    = resp_q;

endmodule

// File: tb/tb_mem_burst_adapter.sv
// Directed bench for mem_burst_adapter: inputs change and outputs are checked on
// the falling edge, so each check sees the state left by the preceding rising edge.
module tb_mem_burst_adapter;

   logic         clk, rst_n;
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
   logic [63:0]  burst_i, burst_o;

   int n_checks = 0;
   int n_fail   = 0;

   mem_burst_adapter dut (
      .clk(clk), .rst_n(rst_n), .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   localparam logic [255:0] LINE_A = {64'h4444444444444444, 64'h3333333333333333,
                                      64'h2222222222222222, 64'h1111111111111111};

   task automatic test_reset();
      rst_n = 1'b0; read_i = 0; write_i = 0; resp_i = 0;
      line_i = '1; address_i = '1; burst_i = '1;
      repeat (2) @(negedge clk);
      n_checks++; if (line_o !== 256'd0) begin n_fail++; $display("FAIL reset_line: got %h want 0", line_o); end
      n_checks++; if (address_o !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", address_o); end
      n_checks++; if (burst_o !== 64'd0) begin n_fail++; $display("FAIL reset_burst: got %h want 0", burst_o); end
      n_checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b want 000", {read_o, write_o, resp_o}); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin n_fail++; $display("FAIL post_reset_idle: got %b want 000", {read_o, write_o, resp_o}); end
   endtask

   task automatic test_read();
      logic [63:0] bt [4];
      bt = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
      address_i = 32'h0000_1234; read_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if ({read_o, write_o, resp_o} !== 3'b100) begin n_fail++; $display("FAIL read_ctl[%0d]: got %b want 100", i, {read_o, write_o, resp_o}); end
         n_checks++; if (address_o !== 32'h0000_1220) begin n_fail++; $display("FAIL read_addr[%0d]: got %h want 00001220", i, address_o); end
         burst_i = bt[i]; resp_i = 1'b1;
      end
      @(negedge clk);
      resp_i = 1'b0;
      n_checks++; if ({read_o, resp_o} !== 2'b01) begin n_fail++; $display("FAIL read_done: got rd/resp %b want 01", {read_o, resp_o}); end
      n_checks++; if (line_o !== LINE_A) begin n_fail++; $display("FAIL read_line: got %h want %h", line_o, LINE_A); end
      read_i = 1'b0; address_i = '0;
      @(negedge clk);
      n_checks++; if ({read_o, resp_o} !== 2'b00) begin n_fail++; $display("FAIL read_idle: got rd/resp %b want 00", {read_o, resp_o}); end
   endtask

   task automatic test_write_stall();
      logic [63:0] d [4];
      logic [63:0] exp_b [7];
      logic        pat [7];
      d     = '{64'hA0A0A0A0A0A0A0A0, 64'hB1B1B1B1B1B1B1B1, 64'hC2C2C2C2C2C2C2C2, 64'hD3D3D3D3D3D3D3D3};
      exp_b = '{d[0], d[1], d[1], d[1], d[2], d[3], d[3]};
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      line_i = {d[3], d[2], d[1], d[0]}; address_i = 32'hDEAD_BEEF; write_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         n_checks++; if ({read_o, write_o, resp_o} !== 3'b010) begin n_fail++; $display("FAIL write_ctl[%0d]: got %b want 010", i, {read_o, write_o, resp_o}); end
         n_checks++; if (burst_o !== exp_b[i]) begin n_fail++; $display("FAIL write_burst[%0d]: got %h want %h", i, burst_o, exp_b[i]); end
         n_checks++; if (address_o !== 32'hDEAD_BEE0) begin n_fail++; $display("FAIL write_addr[%0d]: got %h want deadbee0", i, address_o); end
         resp_i = pat[i]; line_i = ~line_i; address_i = 32'h5555_5555;
      end
      @(negedge clk);
      resp_i = 1'b0;
      n_checks++; if ({write_o, resp_o} !== 2'b01) begin n_fail++; $display("FAIL write_done: got wr/resp %b want 01", {write_o, resp_o}); end
      n_checks++; if (burst_o !== 64'd0) begin n_fail++; $display("FAIL write_burst_done: got %h want 0", burst_o); end
      n_checks++; if (line_o !== LINE_A) begin n_fail++; $display("FAIL write_line_kept: got %h want %h", line_o, LINE_A); end
      write_i = 1'b0;
      @(negedge clk);
      n_checks++; if ({write_o, resp_o} !== 2'b00) begin n_fail++; $display("FAIL write_idle: got wr/resp %b want 00", {write_o, resp_o}); end
   endtask

   task automatic test_both();
      logic [63:0] bt [4];
      bt = '{64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777, 64'h8888888888888888};
      address_i = 32'h4000_00FF; read_i = 1'b1; write_i = 1'b1; line_i = '1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if ({read_o, write_o} !== 2'b10) begin n_fail++; $display("FAIL both_ctl[%0d]: got rd/wr %b want 10", i, {read_o, write_o}); end
         n_checks++; if (burst_o !== 64'd0) begin n_fail++; $display("FAIL both_burst[%0d]: got %h want 0", i, burst_o); end
         burst_i = bt[i]; resp_i = 1'b1;
      end
      @(negedge clk);
      resp_i = 1'b0;
      n_checks++; if ({write_o, resp_o} !== 2'b01) begin n_fail++; $display("FAIL both_done: got wr/resp %b want 01", {write_o, resp_o}); end
      n_checks++; if (address_o !== 32'h4000_00E0) begin n_fail++; $display("FAIL both_addr: got %h want 400000e0", address_o); end
      n_checks++; if (line_o !== {bt[3], bt[2], bt[1], bt[0]}) begin n_fail++; $display("FAIL both_line: got %h", line_o); end
      read_i = 1'b0; write_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [63:0] bt [4];
      bt = '{64'h9999999999999999, 64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 64'hCCCCCCCCCCCCCCCC};
      address_i = 32'h0000_0040; read_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         burst_i = 64'hDEADDEADDEADDEAD ^ 64'(i); resp_i = 1'b1;
      end
      @(negedge clk);
      n_checks++; if (read_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset: read_o %b want 1", read_o); end
      rst_n = 1'b0;
      #1;
      n_checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_ctl: got %b want 000", {read_o, write_o, resp_o}); end
      n_checks++; if (line_o !== 256'd0 || address_o !== 32'd0 || burst_o !== 64'd0) begin n_fail++; $display("FAIL mid_reset_data: line %h addr %h burst %h want 0", line_o, address_o, burst_o); end
      read_i = 1'b0; resp_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if ({read_o, resp_o} !== 2'b00) begin n_fail++; $display("FAIL mid_after_reset: got rd/resp %b want 00", {read_o, resp_o}); end
      address_i = 32'h0000_0080; read_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         burst_i = bt[i]; resp_i = 1'b1;
      end
      @(negedge clk);
      resp_i = 1'b0;
      n_checks++; if (resp_o !== 1'b1) begin n_fail++; $display("FAIL mid_reread_resp: got %b want 1", resp_o); end
      n_checks++; if (line_o !== {bt[3], bt[2], bt[1], bt[0]}) begin n_fail++; $display("FAIL mid_reread_line: got %h", line_o); end
      read_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_idle_resp();
      logic [255:0] prev;
      logic [63:0]  bt [4];
      bt = '{64'h0102030405060708, 64'h1112131415161718, 64'h2122232425262728, 64'h3132333435363738};
      prev = {64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA, 64'h9999999999999999};
      burst_i = 64'hFFFF_FFFF_FFFF_FFFF; resp_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== prev) begin n_fail++; $display("FAIL idle_resp[%0d]: ctl %b line %h", i, {read_o, write_o, resp_o}, line_o); end
      end
      address_i = 32'h0000_0100; read_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         burst_i = bt[i];
      end
      @(negedge clk);
      resp_i = 1'b0;
      n_checks++; if ({read_o, resp_o} !== 2'b01) begin n_fail++; $display("FAIL idle_resp_done: got rd/resp %b want 01", {read_o, resp_o}); end
      n_checks++; if (line_o[63:0] !== 64'h0102030405060708) begin n_fail++; $display("FAIL idle_resp_beat0: got %h want 0102030405060708", line_o[63:0]); end
      n_checks++; if (line_o !== {bt[3], bt[2], bt[1], bt[0]}) begin n_fail++; $display("FAIL idle_resp_line: got %h", line_o); end
      read_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [63:0] a [4];
      logic [63:0] b [4];
      a = '{64'h0F0F0F0F0F0F0F0F, 64'h1E1E1E1E1E1E1E1E, 64'h2D2D2D2D2D2D2D2D, 64'h3C3C3C3C3C3C3C3C};
      b = '{64'h4B4B4B4B4B4B4B4B, 64'h5A5A5A5A5A5A5A5A, 64'h6969696969696969, 64'h7878787878787878};
      address_i = 32'h0000_0200; read_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         burst_i = a[i]; resp_i = 1'b1;
      end
      @(negedge clk);
      resp_i = 1'b0;
      n_checks++; if (resp_o !== 1'b1 || line_o !== {a[3], a[2], a[1], a[0]}) begin n_fail++; $display("FAIL b2b_first: resp %b line %h", resp_o, line_o); end
      address_i = 32'h0000_0300;
      @(negedge clk);
      n_checks++; if ({read_o, resp_o} !== 2'b00) begin n_fail++; $display("FAIL b2b_gap: got rd/resp %b want 00", {read_o, resp_o}); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if (read_o !== 1'b1 || address_o !== 32'h0000_0300) begin n_fail++; $display("FAIL b2b_second[%0d]: rd %b addr %h want 1/00000300", i, read_o, address_o); end
         burst_i = b[i]; resp_i = 1'b1;
      end
      @(negedge clk);
      resp_i = 1'b0;
      n_checks++; if (resp_o !== 1'b1 || line_o !== {b[3], b[2], b[1], b[0]}) begin n_fail++; $display("FAIL b2b_second_done: resp %b line %h", resp_o, line_o); end
      read_i = 1'b0;
      @(negedge clk);
      n_checks++; if ({read_o, resp_o} !== 2'b00) begin n_fail++; $display("FAIL b2b_end: got rd/resp %b want 00", {read_o, resp_o}); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_stall();
      test_both();
      test_reset_mid();
      test_idle_resp();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
